// File: rtl/exp_arbiter.sv
// exp_arbiter: shares one fixed-latency exponent datapath among N_REQ requesters.
// A request is granted, its operand latched and launched into the datapath, the
// result captured after LATENCY cycles and handed back with a one-cycle done pulse.
// Optional build macro: EXP_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, no round-robin pointer); when undefined, arbitration is round-robin.
module exp_arbiter #(
    parameter int N_REQ   = 4,
    parameter int A_W     = 32,
    parameter int B_W     = 41,
    parameter int LATENCY = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*A_W-1:0]   op_a,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [B_W-1:0]         res,
    output logic                   busy,
    output logic [A_W-1:0]         dp_a,
    output logic                   dp_start,
    input  logic [B_W-1:0]         dp_b
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_vld;

`ifndef EXP_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    win_q;
    logic [IDX_W:0]      sum;
`endif

`ifdef EXP_ARB_FIXED_PRIO_EN
    // Fixed-priority pick: the lowest requesting index wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[IDX_W'(k)]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(k);
            end
        end
    end
`else
    // Round-robin pick: scan upward from rr_ptr, wrapping past N_REQ-1 to 0.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        sum      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(N_REQ)) begin
                sum = sum - (IDX_W + 1)'(N_REQ);
            end
            if (!pick_vld && req[sum[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = sum[IDX_W-1:0];
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs (done/busy/dp_start never see req directly).
    always_comb begin
        state_d  = state_q;
        busy     = (state_q != IDLE);
        dp_start = (state_q == START);
        done     = (state_q == DONE) ? gnt : '0;
        case (state_q)
            IDLE:    if (pick_vld) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (cnt_q == CNT_W'(LATENCY - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction registers: grant, operand latch, latency counter, result capture, pointer.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            gnt      <= '0;
            dp_a     <= '0;
            res      <= '0;
            cnt_q    <= '0;
`ifndef EXP_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
            win_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt   <= N_REQ'(1) << pick_idx;
                        dp_a  <= op_a[int'(pick_idx) * A_W +: A_W];
`ifndef EXP_ARB_FIXED_PRIO_EN
                        win_q <= pick_idx;
`endif
                    end
                end
                START: begin
                    cnt_q <= '0;
                end
                WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LATENCY - 1)) begin
                        res <= dp_b;
                    end
                end
                DONE: begin
                    gnt <= '0;
`ifndef EXP_ARB_FIXED_PRIO_EN
                    // The winner just served drops to lowest priority next round.
                    if (win_q == IDX_W'(N_REQ - 1)) begin
                        rr_ptr_q <= '0;
                    end else begin
                        rr_ptr_q <= win_q + IDX_W'(1);
                    end
`endif
                end
                default: begin
                    gnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_arbiter.sv
// Self-checking bench for exp_arbiter: directed scenarios followed by random
// request traffic, checked against a transaction-level reference model through
// a scoreboard queue of expected done pulses.
module tb_exp_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int BW  = 41;
    localparam int LAT = 4;

    logic              Clk   = 1'b0;
    logic              Reset = 1'b1;
    logic [N-1:0]      req   = '0;
    logic [AW-1:0]     ops [N];
    logic [N*AW-1:0]   op_a;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic [BW-1:0]     res;
    logic              busy;
    logic [AW-1:0]     dp_a;
    logic              dp_start;
    logic [BW-1:0]     dp_b;

    typedef struct {
        int            idx;
        int            cyc;
        logic [BW-1:0] r;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    exp_arbiter #(.N_REQ(N), .A_W(AW), .B_W(BW), .LATENCY(LAT)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .op_a(op_a), .gnt(gnt), .done(done),
        .res(res), .busy(busy), .dp_a(dp_a), .dp_start(dp_start), .dp_b(dp_b)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    always_comb begin
        op_a = '0;
        for (int i = 0; i < N; i++) op_a[i*AW +: AW] = ops[i];
    end

    function automatic logic [BW-1:0] dp_fn(input logic [AW-1:0] a);
        return BW'(a) * BW'(3);
    endfunction

    // Datapath stand-in: result is presented only in the cycle LAT after dp_start.
    logic [LAT-1:0] sv = '0;
    logic [AW-1:0]  sa [LAT];
    always @(posedge Clk) begin
        sv[0] <= dp_start;
        sa[0] <= dp_a;
        for (int k = 1; k < LAT; k++) begin
            sv[k] <= sv[k-1];
            sa[k] <= sa[k-1];
        end
    end
    assign dp_b = sv[LAT-1] ? dp_fn(sa[LAT-1]) : ~dp_fn(sa[LAT-1]);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: one transaction occupies LAT+2 busy cycles after the pick cycle.
    initial begin : model
        int            m_left;
        int            m_ptr;
        int            m_win;
        int            start;
        int            idx;
        logic [AW-1:0] m_op;
        logic [N-1:0]  eg;
        m_left = 0; m_ptr = 0; m_win = 0; m_op = '0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                m_left = 0;
                m_ptr  = 0;
            end else begin
                eg = (m_left > 0) ? (N'(1) << m_win) : '0;
                check("ctl_busy_gnt_start", {busy, gnt, dp_start},
                      {(m_left > 0), eg, (m_left == LAT + 2)});
                if (m_left == LAT + 2) check("dp_a", dp_a, m_op);
                if (m_left > 0) begin
                    m_left--;
                end else if (req != '0) begin
`ifdef EXP_ARB_FIXED_PRIO_EN
                    start = 0;
`else
                    start = m_ptr;
`endif
                    m_win = -1;
                    for (int k = 0; k < N; k++) begin
                        idx = (start + k) % N;
                        if (m_win < 0 && req[idx]) m_win = idx;
                    end
                    m_op  = ops[m_win];
                    m_ptr = (m_win + 1) % N;
                    sb.push_back('{m_win, cyc + LAT + 2, dp_fn(m_op)});
                    m_left = LAT + 2;
                end
            end
        end
    end

    // Monitor: every done pulse is matched against the oldest expected transaction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL done_missing: requester %0d got no done, required at cycle %0d", sb[0].idx, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (done !== '0) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", done, '0);
                end else begin
                    e = sb.pop_front();
                    check("done_vec", done, N'(1) << e.idx);
                    check("done_cyc", cyc, e.cyc);
                    check("res", res, e.r);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin : stim
        logic [N-1:0] d;
        logic [N-1:0] g;
        for (int i = 0; i < N; i++) ops[i] = '0;

        // Reset state
        tick(2);
        @(negedge Clk);
        check("rst_gnt", gnt, '0);
        check("rst_done", done, '0);
        check("rst_res", res, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_dp_a", dp_a, '0);
        check("rst_dp_start", dp_start, 1'b0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        tick(2);

        // Single request, res = 1*3
        ops[0] = 32'd1;
        req = 4'b0001;
        tick(7);
        req = '0;
        tick(3);

        // All four held: 0,1,2,3,0
        for (int i = 0; i < N; i++) ops[i] = AW'(i + 1);
        req = 4'b1111;
        tick(35);
        req = '0;
        tick(10);

        // Serve 2 so the pointer sits at 3, then 3 and 0 compete across the wrap
        ops[2] = 32'h0000_1234;
        req = 4'b0100;
        tick(7);
        ops[3] = 32'hDEAD_BEEF;
        ops[0] = 32'hFFFF_FFFF;
        req = 4'b1001;
        tick(14);
        req = '0;
        tick(4);

        // Request dropped while the datapath is busy
        ops[1] = 32'h0BAD_CAFE;
        req = 4'b0010;
        tick(3);
        req = '0;
        tick(8);

        // Reset during WAIT, then the same request is served afresh
        ops[2] = 32'h0000_0777;
        req = 4'b0100;
        tick(3);
        Reset = 1'b1;
        sb.delete();
        tick(1);
        Reset = 1'b0;
        @(negedge Clk);
        check("mid_rst_gnt", gnt, '0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_res", res, '0);
        check("mid_rst_done", done, '0);
        tick(8);
        req = '0;
        tick(4);

        // Random traffic
        for (int t = 0; t < 800; t++) begin
            @(negedge Clk);
            d = done;
            g = gnt;
            @(posedge Clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (d[i]) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                end else if (req[i] && g[i]) begin
                    if ($urandom_range(15, 0) == 0) req[i] = 1'b0;
                end else if (!req[i] && !g[i]) begin
                    if ($urandom_range(3, 0) == 0) begin
                        ops[i] = $urandom;
                        req[i] = 1'b1;
                    end
                end
            end
        end
        req = '0;
        tick(12);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
